// File: rtl/logic_sweep_checker.sv
// Exhaustive input-sweep self-checker: steps every N_IN-bit vector, compares DUT vs golden outputs.
// Optional build macro SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module logic_sweep_checker #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned N_OUT  = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [N_IN-1:0]   vec_out,
    input  logic [N_OUT-1:0]  dut_y,
    input  logic [N_OUT-1:0]  ref_y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic              first_fail_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] ffv_q, ffv_d;
    logic            ffvalid_q, ffvalid_d;

    logic mismatch;
    logic stop_sweep;

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;

        mismatch   = |(dut_y ^ ref_y);
`ifdef SWEEP_STOP_ON_FAIL_EN
        stop_sweep = (&vec_q) | mismatch;
`else
        stop_sweep = &vec_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_WAIT;
                    vec_d     = '0;
                    cnt_d     = SETTLE_M1;
                    err_d     = '0;
                    ffv_d     = '0;
                    ffvalid_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + (N_IN + 1)'(1);
                    if (!ffvalid_q) begin
                        ffv_d     = vec_q;
                        ffvalid_d = 1'b1;
                    end
                end
                // Last vector (or first failure when stopping early) leaves vec_out parked.
                if (stop_sweep) begin
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + N_IN'(1);
                    cnt_d   = SETTLE_M1;
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            vec_q     <= '0;
            cnt_q     <= '0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
        end
    end

    // Status outputs decode registered state only; no path from dut_y/ref_y/start.
    assign vec_out          = vec_q;
    assign busy             = (state_q == S_WAIT) || (state_q == S_CHECK);
    assign done             = (state_q == S_DONE);
    assign pass             = (state_q == S_DONE) && (err_q == '0);
    assign err_count        = err_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_logic_sweep_checker.sv
// Directed bench for logic_sweep_checker: SETTLE=1 instance for sweep/fault/restart/reset, SETTLE=3 for timing.
module tb_logic_sweep_checker;

    logic       clk;
    logic       reset;
    int         mode;
    int         n_vec;
    int         n_err;

    logic       start1, busy1, done1, pass1, ffvalid1;
    logic [3:0] vec1, ffv1;
    logic [1:0] dut1, ref1;
    logic [4:0] err1;

    logic       start3, busy3, done3, pass3, ffvalid3;
    logic [3:0] vec3, ffv3;
    logic [1:0] dut3, ref3;
    logic [4:0] err3;

    logic_sweep_checker #(.N_IN(4), .N_OUT(2), .SETTLE(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .vec_out(vec1),
        .dut_y(dut1), .ref_y(ref1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail_vec(ffv1), .first_fail_valid(ffvalid1)
    );

    logic_sweep_checker #(.N_IN(4), .N_OUT(2), .SETTLE(3)) u3 (
        .clk(clk), .reset(reset), .start(start3), .vec_out(vec3),
        .dut_y(dut3), .ref_y(ref3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_fail_vec(ffv3), .first_fail_valid(ffvalid3)
    );

    always #5 clk = ~clk;

    // Fault scenarios applied to the SETTLE=1 instance
    always_comb begin
        dut1 = vec1[1:0];
        ref1 = vec1[1:0];
        case (mode)
            1: if (vec1 == 4'd5) ref1 = ~vec1[1:0];
            2: dut1[0] = 1'b0;
            3: if (vec1 == 4'd6 || vec1 == 4'd10) ref1 = ~vec1[1:0];
            default: ;
        endcase
    end

    assign dut3 = vec3[1:0];
    assign ref3 = vec3[1:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge with u1 idle or done; returns at the negedge where done is expected.
    task automatic sweep1(input int len, input int exp_err, input int exp_ffv,
                          input int exp_ffvalid, input int exp_vec, input bit hold);
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start1 = 1'b0;
        for (int k = 0; k < len; k++) begin
            check("sweep_vec", vec1, k / 2);
            check("sweep_busy", busy1, 1);
            check("sweep_done", done1, 0);
            if (k == 0) begin
                check("clr_err", err1, 0);
                check("clr_ffvalid", ffvalid1, 0);
            end
            @(negedge clk);
        end
        check("end_done", done1, 1);
        check("end_busy", busy1, 0);
        check("end_pass", pass1, (exp_err == 0) ? 1 : 0);
        check("end_err", err1, exp_err);
        check("end_ffv", ffv1, exp_ffv);
        check("end_ffvalid", ffvalid1, exp_ffvalid);
        check("end_vec", vec1, exp_vec);
    endtask

    initial begin
        int cnt;
        clk    = 1'b0;
        reset  = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        mode   = 0;
        n_vec  = 0;
        n_err  = 0;

        repeat (2) @(negedge clk);
        check("rst_vec", vec1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_pass", pass1, 0);
        check("rst_err", err1, 0);
        check("rst_ffv", ffv1, 0);
        check("rst_ffvalid", ffvalid1, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy1, 0);

        // Clean sweep, then results must hold in DONE
        sweep1(32, 0, 0, 0, 15, 1'b0);
        repeat (3) @(negedge clk);
        check("hold_done", done1, 1);
        check("hold_pass", pass1, 1);
        check("hold_vec", vec1, 15);

        mode = 1;
`ifdef SWEEP_STOP_ON_FAIL_EN
        sweep1(12, 1, 5, 1, 5, 1'b0);
`else
        sweep1(32, 1, 5, 1, 15, 1'b0);
`endif

        mode = 2;
`ifdef SWEEP_STOP_ON_FAIL_EN
        sweep1(4, 1, 1, 1, 1, 1'b0);
`else
        sweep1(32, 8, 1, 1, 15, 1'b0);
`endif

        mode = 3;
`ifdef SWEEP_STOP_ON_FAIL_EN
        sweep1(14, 1, 6, 1, 6, 1'b0);
`else
        sweep1(32, 2, 6, 1, 15, 1'b0);
`endif

        // start held high: no mid-sweep restart, immediate restart from DONE
        mode = 0;
        sweep1(32, 0, 0, 0, 15, 1'b1);
        @(negedge clk);
        check("restart_busy", busy1, 1);
        check("restart_done", done1, 0);
        check("restart_vec", vec1, 0);
        check("restart_err", err1, 0);
        repeat (18) @(negedge clk);
        check("pre_reset_vec", vec1, 9);
        reset  = 1'b1;
        start1 = 1'b0;
        @(negedge clk);
        check("mid_rst_vec", vec1, 0);
        check("mid_rst_busy", busy1, 0);
        check("mid_rst_done", done1, 0);
        check("mid_rst_pass", pass1, 0);
        check("mid_rst_err", err1, 0);
        check("mid_rst_ffvalid", ffvalid1, 0);
        reset = 1'b0;
        @(negedge clk);

        // SETTLE=3: four cycles per vector, 64 to done
        start3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start3 = 1'b0;
        cnt = 0;
        check("s3_busy", busy3, 1);
        while (!done3 && cnt < 200) begin
            if (cnt == 3) check("s3_vec_k3", vec3, 0);
            if (cnt == 4) check("s3_vec_k4", vec3, 1);
            @(negedge clk);
            cnt++;
        end
        check("s3_len", cnt, 64);
        check("s3_pass", pass3, 1);
        check("s3_err", err3, 0);
        check("s3_vec", vec3, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/logic_sweep_checker.md
# logic_sweep_checker

Synthesizable exhaustive-sweep self-checker for small combinational blocks. It drives every input combination of an N_IN-bit DUT in ascending binary order and waits a configurable settle time. It compares the DUT outputs against a golden-model output bus and reports pass/fail, the mismatch count and the first failing vector. It sits on the board beside the block under test, with results routed to LEDs or 7-segment displays, replacing simulation-only stimulus sweeps.

## Interface
- N_IN, 4, DUT input width; sweep covers 2^N_IN vectors (legal 1..16)
- N_OUT, 2, DUT output width compared per vector (legal 1..32)
- SETTLE, 1, clock cycles a vector is held before sampling (legal 1..255)
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-high; one clock; all state cleared at the next rising edge
- start  input  1  level; sampled in IDLE or DONE, begins a sweep
- vec_out  output  N_IN  vector driven to DUT and golden model
- dut_y  input  N_OUT  DUT outputs
- ref_y  input  N_OUT  golden-model outputs
- busy  output  1  high from the cycle after start is accepted until DONE
- done  output  1  high while in DONE
- pass  output  1  valid when done; 1 iff err_count == 0
- err_count  output  N_IN+1  mismatching vectors this sweep (saturation impossible, max 2^N_IN)
- first_fail_vec  output  N_IN  vector of first mismatch
- first_fail_valid  output  1  first_fail_vec holds a captured value

## Operation
- FSM states: IDLE, WAIT, CHECK, DONE.
- IDLE: all outputs at reset value; start=1 -> WAIT, vec_out=0, settle counter=SETTLE-1, err_count/first_fail cleared.
- WAIT: counter decrements each cycle; at 0 -> CHECK.
- CHECK: one cycle; mismatch = |(dut_y ^ ref_y).
  - Mismatch: err_count+1. If first_fail_valid=0, capture first_fail_vec=vec_out and set first_fail_valid.
  - vec_out != all-ones: vec_out+1, reload counter, -> WAIT.
  - vec_out == all-ones: -> DONE. No wrap; vec_out holds all-ones.
- DONE: done=1, pass=(err_count==0). Results hold until start=1, which behaves as in IDLE: clear results, restart at vector 0.
- start is ignored in WAIT/CHECK; no restart mid-sweep.
- Reset in any state: next edge -> IDLE, all outputs at reset values. Any partial sweep is discarded.

## Timing
- Reset values: vec_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0.
- Start accepted at edge E: vec_out=0 and busy=1 from E.
- Each vector occupies SETTLE+1 cycles: SETTLE in WAIT, 1 in CHECK. dut_y/ref_y are sampled at the CHECK-ending edge.
- The DUT path must settle within SETTLE cycles of the vec_out change.
- Sweep length: 2^N_IN×(SETTLE+1) cycles from E. done=1 and busy=0 in the following cycle.
- err_count and first_fail_* update at the edge ending CHECK and are visible the next cycle.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- SWEEP_STOP_ON_FAIL_EN defined: the first mismatch in CHECK moves the FSM to DONE, with err_count=1, pass=0, and vec_out held at the failing vector.
- SWEEP_STOP_ON_FAIL_EN undefined: the full sweep always runs and all mismatches are counted.

## Test plan
- N_IN=4, N_OUT=2, SETTLE=1, dut_y tied to ref_y; start pulse -> vec_out steps 0..15, two cycles each; done after 32 cycles; pass=1, err_count=0, first_fail_valid=0.
- ref_y inverted only when vec_out==5 -> err_count=1, first_fail_vec=5, first_fail_valid=1, pass=0.
- dut_y[0] stuck at 0, ref_y[0]=vec_out[0] -> err_count=8, first_fail_vec=1.
- start held high through the sweep -> no restart until DONE, then an immediate new sweep with results cleared; reset asserted at vector 9 -> next cycle IDLE with all outputs 0.
- SETTLE=3 -> each vector held 4 cycles; done after 64 cycles.
- SWEEP_STOP_ON_FAIL_EN defined, mismatch at vector 6 and vector 10 -> done one cycle after vector 6 is checked; err_count=1, vec_out=6, first_fail_vec=6.
